// File: rtl/fetch_stage_pkg.sv
// Shared constants for the instruction-fetch slice.
package fetch_stage_pkg;

  localparam int          CPU_XLEN     = 32;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [31:0] CPU_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface fetch_stage_if #(
  parameter int XLEN = fetch_stage_pkg::CPU_XLEN
) ();

  logic            req;
  logic [XLEN-1:0] addr;
  logic            rsp_valid;
  logic [XLEN-1:0] rdata;

  modport master (output req, addr, input rsp_valid, rdata);
  modport slave  (input req, addr, output rsp_valid, rdata);

endinterface

// File: rtl/fetch_stage_fifo.sv
// Synchronous FIFO with clear; clear takes priority over push/pop.
module fetch_stage_fifo
  import fetch_stage_pkg::*;
#(
  parameter int WIDTH = CPU_XLEN,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/fetch_stage.sv
// IF stage: issues in-order imem requests, buffers returns, drives the IF/ID register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int              XLEN      = CPU_XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(CPU_RESET_PC),
  parameter int              MAX_OUT   = 2,
  parameter int              BUF_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             pc_write,
  input  logic             stall,
  input  logic             flush,
  input  logic [XLEN-1:0]  branch_target,
  fetch_stage_if.master    imem,
  output logic [XLEN-1:0]  if_id_pc,
  output logic [XLEN-1:0]  if_id_instr,
  output logic             if_id_valid
);

  localparam int OUT_W  = $clog2(MAX_OUT + 1);
  localparam int BUF_W  = $clog2(BUF_DEPTH + 1);
  localparam int DROP_W = OUT_W + 4;

  logic [XLEN-1:0]   pc;
  logic [DROP_W-1:0] drop_cnt;
  logic [OUT_W-1:0]  out_cnt;
  logic [BUF_W-1:0]  buf_cnt;
  logic              pend_full;
  logic              pend_empty;
  logic              buf_full;
  logic              buf_empty;
  logic [XLEN-1:0]   pend_pc;
  logic [2*XLEN-1:0] buf_head;
  logic              issue;
  logic              drop_rsp;
  logic              live_rsp;
  logic              advance;

  // Pending FIFO depth equals MAX_OUT, so its count doubles as out_cnt.
  assign issue = start & pc_write & ~flush & ~pend_full & ~buf_full &
                 ((32'(out_cnt) + 32'(buf_cnt)) < 32'(BUF_DEPTH));

  assign drop_rsp = imem.rsp_valid & (drop_cnt != '0);
  assign live_rsp = imem.rsp_valid & (drop_cnt == '0) & ~pend_empty;
  assign advance  = ~flush & ~stall & ~buf_empty;

  assign imem.req  = issue;
  assign imem.addr = pc;

  fetch_stage_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUT)) u_pend (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush),
    .push  (issue),
    .pop   (live_rsp),
    .wdata (pc),
    .rdata (pend_pc),
    .count (out_cnt),
    .full  (pend_full),
    .empty (pend_empty)
  );

  fetch_stage_fifo #(.WIDTH(2*XLEN), .DEPTH(BUF_DEPTH)) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush),
    .push  (live_rsp),
    .pop   (advance),
    .wdata ({pend_pc, imem.rdata}),
    .rdata (buf_head),
    .count (buf_cnt),
    .full  (buf_full),
    .empty (buf_empty)
  );

  // IF -> ID boundary: flush beats stall beats advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      drop_cnt    <= '0;
      if_id_valid <= 1'b0;
      if_id_instr <= XLEN'(NOP_INSTR);
      if_id_pc    <= '0;
    end else if (flush) begin
      pc          <= branch_target;
      drop_cnt    <= drop_cnt + DROP_W'(out_cnt) - DROP_W'(live_rsp | drop_rsp);
      if_id_valid <= 1'b0;
      if_id_instr <= XLEN'(NOP_INSTR);
      if_id_pc    <= '0;
    end else begin
      if (issue)    pc <= pc + XLEN'(4);
      if (drop_rsp) drop_cnt <= drop_cnt - DROP_W'(1);
      if (!stall) begin
        if (!buf_empty) begin
          if_id_valid <= 1'b1;
          if_id_pc    <= buf_head[2*XLEN-1:XLEN];
          if_id_instr <= buf_head[XLEN-1:0];
        end else begin
          if_id_valid <= 1'b0;
          if_id_instr <= XLEN'(NOP_INSTR);
          if_id_pc    <= '0;
        end
      end
    end
  end

endmodule
